// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-side issue/writeback stage around a combinational ALU.
// Instructions enter over valid/ready, read operands from an internal register
// file (with E/W forwarding), sit in E while the ALU works, and retire via W.
module alu_issue_stage #(
    parameter int          DATA_W     = 16,
    parameter int          NREGS      = 8,
    parameter int          RADDR_W    = 3,
    parameter int          MUL_LAT    = 2,
    parameter logic [3:0]  ALU_OP_MUL = 4'd5
) (
    input  logic               clk,
    input  logic               rst_n,
    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both 1 and flush is 0. in_ready never depends on in_valid.
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [RADDR_W-1:0] in_ra,
    input  logic [RADDR_W-1:0] in_rb,
    input  logic               in_use_imm,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic               in_wen,
    input  logic               flush,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_op,
    input  logic [DATA_W-1:0]  alu_result,
    output logic               wb_valid,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]  wb_data,
    input  logic [RADDR_W-1:0] dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);

    // E stage
    logic               e_valid_q, e_valid_d;
    logic [3:0]         e_op_q, e_op_d;
    logic [DATA_W-1:0]  e_a_q, e_a_d;
    logic [DATA_W-1:0]  e_b_q, e_b_d;
    logic [RADDR_W-1:0] e_rd_q, e_rd_d;
    logic               e_wen_q, e_wen_d;
    logic [CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
    // W stage
    logic               w_valid_q, w_valid_d;
    logic               w_wen_q, w_wen_d;
    logic [RADDR_W-1:0] w_rd_q, w_rd_d;
    logic [DATA_W-1:0]  w_data_q, w_data_d;
    // Register file
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [DATA_W-1:0]  regs_d [NREGS];

    logic e_is_mul, e_done, accept;
    logic [DATA_W-1:0] opnd_a, opnd_b;

    // Operand source selection: r0, then E result completing now, then W, then array.
    function automatic logic [DATA_W-1:0] read_src(
        input logic [RADDR_W-1:0] addr,
        input logic               e_fwd,
        input logic [RADDR_W-1:0] e_rd,
        input logic [DATA_W-1:0]  e_res,
        input logic               w_fwd,
        input logic [RADDR_W-1:0] w_rd,
        input logic [DATA_W-1:0]  w_data,
        input logic [DATA_W-1:0]  arr
    );
        if (addr == '0)                 return '0;
        else if (e_fwd && e_rd == addr) return e_res;
        else if (w_fwd && w_rd == addr) return w_data;
        else                            return arr;
    endfunction

    // Stall / completion / acceptance decode and operand reads.
    always_comb begin
        e_is_mul = (e_op_q == ALU_OP_MUL);
        e_done   = e_valid_q && (!e_is_mul || mul_cnt_q == CNT_LAST);
        // Held low in reset so nothing is offered a transfer it cannot make.
        in_ready = rst_n && !(e_valid_q && e_is_mul && mul_cnt_q != CNT_LAST);
        accept   = in_valid && in_ready && !flush;
        opnd_a   = read_src(in_ra, e_done && e_wen_q, e_rd_q, alu_result,
                            w_valid_q && w_wen_q, w_rd_q, w_data_q, regs_q[in_ra]);
        opnd_b   = in_use_imm ? in_imm
                 : read_src(in_rb, e_done && e_wen_q, e_rd_q, alu_result,
                            w_valid_q && w_wen_q, w_rd_q, w_data_q, regs_q[in_rb]);
    end

    // Next-state for E, the MUL counter, W and the register array.
    always_comb begin
        e_valid_d = e_valid_q;
        e_op_d    = e_op_q;
        e_a_d     = e_a_q;
        e_b_d     = e_b_q;
        e_rd_d    = e_rd_q;
        e_wen_d   = e_wen_q;
        mul_cnt_d = mul_cnt_q;
        w_valid_d = 1'b0;
        w_wen_d   = w_wen_q;
        w_rd_d    = w_rd_q;
        w_data_d  = w_data_q;
        regs_d    = regs_q;

        // A flushed E never reaches W, even if it would complete this cycle.
        if (e_done && !flush) begin
            w_valid_d = 1'b1;
            w_wen_d   = e_wen_q;
            w_rd_d    = e_rd_q;
            w_data_d  = alu_result;
        end

        if (flush) begin
            e_valid_d = 1'b0;
            mul_cnt_d = '0;
        end else if (accept) begin
            e_valid_d = 1'b1;
            e_op_d    = in_op;
            e_a_d     = opnd_a;
            e_b_d     = opnd_b;
            e_rd_d    = in_rd;
            e_wen_d   = in_wen;
            mul_cnt_d = '0;
        end else if (e_done) begin
            // Operands stay on the ALU inputs; only the valid drops.
            e_valid_d = 1'b0;
            mul_cnt_d = '0;
        end else if (e_valid_q && e_is_mul) begin
            mul_cnt_d = mul_cnt_q + 1'b1;
        end

        if (w_valid_q && w_wen_q && w_rd_q != '0) begin
            regs_d[w_rd_q] = w_data_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_q <= 1'b0;
            e_op_q    <= '0;
            e_a_q     <= '0;
            e_b_q     <= '0;
            e_rd_q    <= '0;
            e_wen_q   <= 1'b0;
            mul_cnt_q <= '0;
            w_valid_q <= 1'b0;
            w_wen_q   <= 1'b0;
            w_rd_q    <= '0;
            w_data_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_op_q    <= e_op_d;
            e_a_q     <= e_a_d;
            e_b_q     <= e_b_d;
            e_rd_q    <= e_rd_d;
            e_wen_q   <= e_wen_d;
            mul_cnt_q <= mul_cnt_d;
            w_valid_q <= w_valid_d;
            w_wen_q   <= w_wen_d;
            w_rd_q    <= w_rd_d;
            w_data_q  <= w_data_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Output wiring; debug port reads the array without forwarding.
    always_comb begin
        alu_a     = e_a_q;
        alu_b     = e_b_q;
        alu_op    = e_op_q;
        wb_valid  = w_valid_q;
        wb_we     = w_valid_q && w_wen_q;
        wb_rd     = w_rd_q;
        wb_data   = w_data_q;
        dbg_rdata = regs_q[dbg_raddr];
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage with a small behavioural ALU model.
module tb_alu_issue_stage;

  localparam int DATA_W = 16;
  localparam int RADDR_W = 3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_LD  = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;
  localparam logic [3:0] OP_MUL = 4'd5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_op = '0;
  logic [RADDR_W-1:0] in_rd = '0, in_ra = '0, in_rb = '0;
  logic               in_use_imm = 1'b0;
  logic [DATA_W-1:0]  in_imm = '0;
  logic               in_wen = 1'b0;
  logic               flush = 1'b0;
  logic [DATA_W-1:0]  alu_a, alu_b;
  logic [3:0]         alu_op;
  logic [DATA_W-1:0]  alu_result;
  logic               wb_valid, wb_we;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [RADDR_W-1:0] dbg_raddr = '0;
  logic [DATA_W-1:0]  dbg_rdata;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(
    .DATA_W(DATA_W), .NREGS(8), .RADDR_W(RADDR_W), .MUL_LAT(2), .ALU_OP_MUL(OP_MUL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_ra(in_ra), .in_rb(in_rb), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_wen(in_wen), .flush(flush),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  // clock
  always #10 clk = ~clk;

  // reference combinational ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_INC:  alu_result = alu_a + 16'd1;
      OP_LD:   alu_result = alu_b;
      OP_CMP:  alu_result = (alu_a == alu_b) ? 16'd1 : 16'd0;
      OP_MUL:  alu_result = alu_a * alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [RADDR_W-1:0] idx,
                           input logic [DATA_W-1:0] exp);
    dbg_raddr = idx;
    #1;
    check(tag, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic drive(input logic [3:0] op, input logic [RADDR_W-1:0] rd,
                       input logic [RADDR_W-1:0] ra, input logic [RADDR_W-1:0] rb,
                       input logic use_imm, input logic [DATA_W-1:0] imm,
                       input logic wen);
    in_valid   = 1'b1;
    in_op      = op;
    in_rd      = rd;
    in_ra      = ra;
    in_rb      = rb;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_wen     = wen;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    tick();

    // ---- forwarding chain: r1=5, r2=r1+r1, r3=r1+r2 ----
    drive(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 1'b1);
    tick();
    check("chain_alu_a", 32'(alu_a), 0);
    check("chain_alu_b", 32'(alu_b), 5);
    drive(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0, 1'b1);
    tick();
    check("chain_wb1_valid", 32'(wb_valid), 1);
    check("chain_wb1_rd", 32'(wb_rd), 1);
    check("chain_wb1_data", 32'(wb_data), 5);
    drive(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, 1'b1);
    tick();
    check("chain_wb2_data", 32'(wb_data), 10);
    check("chain_wb2_rd", 32'(wb_rd), 2);
    idle();
    tick();
    check("chain_wb3_valid", 32'(wb_valid), 1);
    check("chain_wb3_data", 32'(wb_data), 15);
    tick();
    check("chain_wb_idle", 32'(wb_valid), 0);
    check_reg("chain_r1", 3'd1, 16'd5);
    check_reg("chain_r2", 3'd2, 16'd10);
    check_reg("chain_r3", 3'd3, 16'd15);

    // ---- MUL stall: r1=7, r2=r1*r1, r3=r2+1 ----
    drive(OP_LD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd7, 1'b1);
    tick();
    drive(OP_MUL, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0, 1'b1);
    tick();
    drive(OP_INC, 3'd3, 3'd2, 3'd0, 1'b0, 16'd0, 1'b1);
    check("mul_ready0", 32'(in_ready), 0);
    check("mul_a_c0", 32'(alu_a), 7);
    check("mul_op_c0", 32'(alu_op), 32'(OP_MUL));
    tick();
    check("mul_ready1", 32'(in_ready), 1);
    check("mul_a_c1", 32'(alu_a), 7);
    check("mul_b_c1", 32'(alu_b), 7);
    check("mul_no_wb", 32'(wb_valid), 0);
    tick();
    idle();
    check("mul_wb_valid", 32'(wb_valid), 1);
    check("mul_wb_rd", 32'(wb_rd), 2);
    check("mul_wb_data", 32'(wb_data), 49);
    check("inc_alu_a", 32'(alu_a), 49);
    tick();
    check("inc_wb_rd", 32'(wb_rd), 3);
    check("inc_wb_data", 32'(wb_data), 50);
    tick();
    check_reg("mul_r2", 3'd2, 16'd49);
    check_reg("inc_r3", 3'd3, 16'd50);

    // ---- r0 protection ----
    drive(OP_LD, 3'd0, 3'd0, 3'd0, 1'b1, 16'hBEEF, 1'b1);
    tick();
    drive(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b0, 16'd0, 1'b1);
    tick();
    idle();
    check("r0_wb_rd", 32'(wb_rd), 0);
    tick();
    check("r0_dep_rd", 32'(wb_rd), 1);
    check("r0_dep_data", 32'(wb_data), 0);
    tick();
    check_reg("r0_dbg", 3'd0, 16'd0);
    check_reg("r0_r1", 3'd1, 16'd0);

    // ---- in_wen=0: r4=3, CMP r4 vs imm 3 without write ----
    drive(OP_LD, 3'd4, 3'd0, 3'd0, 1'b1, 16'd3, 1'b1);
    tick();
    drive(OP_CMP, 3'd4, 3'd4, 3'd0, 1'b1, 16'd3, 1'b0);
    tick();
    idle();
    tick();
    check("cmp_wb_valid", 32'(wb_valid), 1);
    check("cmp_wb_we", 32'(wb_we), 0);
    check("cmp_wb_data", 32'(wb_data), 1);
    tick();
    check_reg("cmp_r4", 3'd4, 16'd3);

    // ---- flush during MUL ----
    drive(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'd9, 1'b1);
    tick();
    drive(OP_MUL, 3'd6, 3'd4, 3'd4, 1'b0, 16'd0, 1'b1);
    tick();
    drive(OP_LD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0077, 1'b1);
    flush = 1'b1;
    check("fl_add_wb_valid", 32'(wb_valid), 1);
    check("fl_add_wb_data", 32'(wb_data), 9);
    tick();
    flush = 1'b0;
    check("fl_no_wb", 32'(wb_valid), 0);
    check("fl_ready", 32'(in_ready), 1);
    drive(OP_ADD, 3'd7, 3'd4, 3'd0, 1'b1, 16'd1, 1'b1);
    tick();
    idle();
    check("fl_no_mul_wb", 32'(wb_valid), 0);
    tick();
    check("fl_next_rd", 32'(wb_rd), 7);
    check("fl_next_data", 32'(wb_data), 4);
    tick();
    check_reg("fl_r5", 3'd5, 16'd9);
    check_reg("fl_r6", 3'd6, 16'd0);
    check_reg("fl_r7", 3'd7, 16'd4);

    // ---- reset mid-stream with E and W both valid ----
    drive(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd2, 1'b1);
    tick();
    drive(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("mrst_wb_valid", 32'(wb_valid), 0);
    check("mrst_alu_a", 32'(alu_a), 0);
    check("mrst_alu_b", 32'(alu_b), 0);
    check("mrst_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < 8; i++) begin
      check_reg("mrst_reg", RADDR_W'(i), 16'd0);
    end
    rst_n = 1'b1;
    #1;
    check("mrst_rel_ready", 32'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Execute-side issue/writeback stage wrapped around the combinational ALU.
- Accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file, with forwarding.
- Drives the ALU inputs from a registered E stage, captures the ALU result into a registered W stage, and writes it back.
- MUL holds E for a configurable number of cycles to relax the multiplier path.

Parameters:
- DATA_W, 16, datapath width; must match ALU a/b/alu_out.
- NREGS, 8, register count; r0 reads as 0 and ignores writes.
- RADDR_W, 3, register address width (log2 NREGS).
- MUL_LAT, 2, cycles E is occupied by `ALU_OP_MUL; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_op  in  4  ALU opcode (const.vh `ALU_OP_*).
- in_rd  in  RADDR_W  destination register.
- in_ra  in  RADDR_W  source A register.
- in_rb  in  RADDR_W  source B register.
- in_use_imm  in  1  1: B operand = in_imm.
- in_imm  in  DATA_W  immediate.
- in_wen  in  1  write result to in_rd.
- flush  in  1  synchronous kill of E and input.
- alu_a  out  DATA_W  ALU operand a (E register).
- alu_b  out  DATA_W  ALU operand b (E register).
- alu_op  out  4  ALU opcode (E register).
- alu_result  in  DATA_W  ALU alu_out.
- wb_valid  out  1  W holds a completed instruction.
- wb_we  out  1  W result is being written.
- wb_rd  out  RADDR_W  W destination.
- wb_data  out  DATA_W  W result.
- dbg_raddr  in  RADDR_W  debug read address.
- dbg_rdata  out  DATA_W  register-file contents at dbg_raddr; reads the array only, no forwarding.

Behaviour:
Reset (rst_n=0, async):
- E/W valid=0, MUL counter=0, register file all 0.
- alu_a/alu_b/alu_op/wb_*=0; in_ready=0 while in reset.

Acceptance:
- Accept on clock edge where in_valid && in_ready && !flush.
- in_ready = !(E valid && E op is MUL && counter != MUL_LAT-1).

Operand read at accept, priority high→low (for ra, and for rb when !in_use_imm):
- (a) address 0 → 0.
- (b) E valid, E wen, E rd matches, E completing this cycle → alu_result.
- (c) W valid, W wen, W rd matches → wb_data.
- (d) register array.

E stage:
- Accepted instruction appears on alu_a/alu_b/alu_op the next cycle; E valid.
- Non-MUL: completes in 1 cycle.
- MUL: counter counts 0..MUL_LAT-1 and completes when counter==MUL_LAT-1; alu_a/alu_b/alu_op stay stable throughout.
- When E completes without a new accept, E valid→0 and alu_a/alu_b/alu_op hold their last value.

W stage:
- On E completion edge: W captures alu_result, rd, and wen; wb_valid=1 for exactly one cycle per instruction; wb_we=wb_valid && wen.
- Register array written at the end of that cycle when wb_we && wb_rd!=0.

Latency:
- Accept edge k → alu_* valid cycle k+1 → wb_valid cycle k+2 (non-MUL), or k+1+MUL_LAT (MUL).
- Array visible (dbg_rdata) from cycle k+3 (non-MUL); dependents issued earlier receive the value via forwarding, no stall.
- Throughput: 1 instr/cycle for non-MUL.

Flush:
- Clears E valid and the MUL counter; the same-cycle input is not accepted.
- An instruction already in W still commits.
- E being killed mid-MUL produces no wb_valid.

Boundary and width rules:
- Simultaneous W write and array read of the same register returns the forwarded value (c), never stale data.
- in_wen=0: wb_valid pulses, wb_we=0, no array write, no forwarding.
- Writes to r0 are dropped; forwarding never supplies r0.
- All arithmetic is done by the ALU; this block only registers DATA_W values, with no width extension.

Test Plan:
- Reset mid-stream: E and W valid, assert rst_n=0 → wb_valid, alu_*, and all dbg_rdata =0 immediately; after release, in_ready=1 on the first cycle.
- Back-to-back dependency, forwarding through E then W:
  - Issue ADD r1=r0+imm 5, then ADD r2=r1+r1, then ADD r3=r1+r2 on consecutive cycles.
  - Required: wb_data 5, 10, 15 on consecutive cycles; dbg r3=15.
- MUL stall, MUL_LAT=2:
  - r1=7; issue MUL r2=r1*r1, then INC r3=r2 presented the next cycle.
  - Required: in_ready=0 for 1 cycle; alu_a=7 stable for 2 cycles; wb r2=49; then wb r3=50.
- r0 protection: LD r0=imm 0xBEEF, then ADD r1=r0+r0 → wb_data for r1 = 0; dbg r0=0.
- in_wen=0: r4=3, then CMP r4 (wen=0) with r4 vs imm 3 → wb_valid=1, wb_we=0, wb_data=1; r4 stays 3.
- Flush during MUL: flush in the first MUL cycle → no wb_valid for the MUL; the preceding ADD in W still writes; the next accepted instruction proceeds normally.
